// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA frame reader slice: default XGA-style
// timing constants, RGB565 colour constants and the reader FSM encoding.
// No ports; imported by vga_timing_gen and vga_frame_reader.
package vga_pkg;

  // Default 1024x768 timing (H_TOTAL = 1344, V_TOTAL = 806)
  localparam int DEF_H_ACTIVE = 1024;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 136;
  localparam int DEF_H_BP     = 160;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 29;
  localparam int DEF_TOGGLE_W = 4;

  // RGB565 colours
  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_RED   = 16'hF800;

  // Frame reader state machine
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } reader_state_t;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running horizontal/vertical counters and the stage-0 (unregistered)
// timing decodes derived from them.
// Ports:
//   clk, rst_n      pixel clock, async active-low reset
//   o_active        stage-0 inside the visible area
//   o_hs, o_vs      stage-0 syncs, active low
//   o_frameEnd      last pixel of the frame (counters wrap to 0,0 next)
//   o_vblankStart   h_cnt=0 on the first line after the active area
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_active,
  output logic o_hs,
  output logic o_vs,
  output logic o_frameEnd,
  output logic o_vblankStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_hCnt;
  logic [9:0]  r_vCnt;

  // Counters never stop, whatever the reader is doing, so the monitor
  // always sees a valid raster.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (r_hCnt == H_LAST) begin
      r_hCnt <= '0;
      r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + 10'd1;
    end else begin
      r_hCnt <= r_hCnt + 11'd1;
    end
  end

  assign o_active      = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
  assign o_hs          = !((r_hCnt >= H_SYNC_BEG) && (r_hCnt < H_SYNC_END));
  assign o_vs          = !((r_vCnt >= V_SYNC_BEG) && (r_vCnt < V_SYNC_END));
  assign o_frameEnd    = (r_hCnt == H_LAST) && (r_vCnt == V_LAST);
  assign o_vblankStart = (r_hCnt == 11'd0) && (r_vCnt == V_ACT);

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader
// Streams RGB565 pixels from an SDRAM frame buffer read port to a VGA
// output, requests a buffer swap once per frame and records underruns.
// Ports:
//   clk, rst_n       pixel / read-port clock, async active-low reset
//   mem_rdy          SDRAM init done (asynchronous, synchronised here)
//   mem_toggle       buffer-swap request pulse, TOGGLE_W cycles wide
//   mem_rdy_to_rd    read data available
//   mem_rd_req       pop one word (combinational)
//   mem_dout         read word, valid the cycle after mem_rd_req
//   vga_hs/vs/de     registered timing outputs
//   vga_rgb          pixel colour aligned with vga_de
//   underrun         sticky underrun flag
//   underrun_cnt     saturating count of underrun pixels
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE       = DEF_H_ACTIVE,
  parameter int          H_FP           = DEF_H_FP,
  parameter int          H_SYNC         = DEF_H_SYNC,
  parameter int          H_BP           = DEF_H_BP,
  parameter int          V_ACTIVE       = DEF_V_ACTIVE,
  parameter int          V_FP           = DEF_V_FP,
  parameter int          V_SYNC         = DEF_V_SYNC,
  parameter int          V_BP           = DEF_V_BP,
  parameter int          TOGGLE_W       = DEF_TOGGLE_W,
  parameter logic [15:0] UNDERRUN_COLOR = RGB565_RED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rdy,
  output logic        mem_toggle,
  input  logic        mem_rdy_to_rd,
  output logic        mem_rd_req,
  input  logic [15:0] mem_dout,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [15:0] vga_rgb,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  localparam int TCW = (TOGGLE_W > 1) ? $clog2(TOGGLE_W) : 1;

  logic w_active;
  logic w_hs;
  logic w_vs;
  logic w_frameEnd;
  logic w_vblankStart;
  logic w_underrunEvt;

  reader_state_t  r_state;
  logic           r_rdyMeta;
  logic           r_rdyS;
  logic           r_toggle;
  logic [TCW-1:0] r_togLeft;
  logic           r_armDone;
  logic           r_hs;
  logic           r_vs;
  logic           r_de;
  logic           r_reqD;
  logic           r_runD;
  logic           r_underrun;
  logic [15:0]    r_underrunCnt;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_active     (w_active),
    .o_hs         (w_hs),
    .o_vs         (w_vs),
    .o_frameEnd   (w_frameEnd),
    .o_vblankStart(w_vblankStart)
  );

  // mem_rdy comes from the SDRAM controller's own domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdyMeta <= 1'b0;
      r_rdyS    <= 1'b0;
    end else begin
      r_rdyMeta <= mem_rdy;
      r_rdyS    <= r_rdyMeta;
    end
  end

  // Reader FSM plus swap pulse. RUN is entered on the frame's last pixel so
  // that the state is already RUN when the counters sit at 0,0. r_armDone
  // remembers that a swap issued while armed has finished, so reading only
  // starts from a freshly swapped buffer. A pulse always runs to its end,
  // even if the reader drops back to IDLE meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_toggle  <= 1'b0;
      r_togLeft <= '0;
      r_armDone <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_armDone <= 1'b0;
          if (r_rdyS) r_state <= ST_ARM;
        end
        ST_ARM: begin
          if (!r_rdyS) r_state <= ST_IDLE;
          else if (w_frameEnd && r_armDone) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (!r_rdyS) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_vblankStart && (r_state != ST_IDLE) && !r_toggle) begin
        r_toggle  <= 1'b1;
        r_togLeft <= TCW'(TOGGLE_W - 1);
      end else if (r_toggle) begin
        if (r_togLeft == '0) begin
          r_toggle <= 1'b0;
          if (r_state == ST_ARM) r_armDone <= 1'b1;
        end else begin
          r_togLeft <= r_togLeft - 1'b1;
        end
      end
    end
  end

  assign mem_rd_req    = (r_state == ST_RUN) && w_active && mem_rdy_to_rd;
  assign w_underrunEvt = (r_state == ST_RUN) && w_active && !mem_rdy_to_rd;

  // One-cycle pipeline matching the read latency of mem_dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_de          <= 1'b0;
      r_reqD        <= 1'b0;
      r_runD        <= 1'b0;
      r_underrun    <= 1'b0;
      r_underrunCnt <= '0;
    end else begin
      r_hs   <= w_hs;
      r_vs   <= w_vs;
      r_de   <= w_active;
      r_reqD <= mem_rd_req;
      r_runD <= (r_state == ST_RUN);
      if (w_underrunEvt) begin
        r_underrun <= 1'b1;
        if (r_underrunCnt != 16'hFFFF) r_underrunCnt <= r_underrunCnt + 16'd1;
      end
    end
  end

  always_comb begin
    vga_rgb = RGB565_BLACK;
    if (r_reqD) vga_rgb = mem_dout;
    else if (r_de && r_runD) vga_rgb = UNDERRUN_COLOR;
  end

  assign mem_toggle   = r_toggle;
  assign vga_hs       = r_hs;
  assign vga_vs       = r_vs;
  assign vga_de       = r_de;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrunCnt;

endmodule
